// File: rtl/cube_pkg.sv
// Shared definitions for the light-cube scan engine: default geometry,
// derived address width and the scan FSM state encoding.
package cube_pkg;

    localparam int N_DEF         = 8;
    localparam int DWELL_W_DEF   = 16;
    localparam int SPEED_W_DEF   = 4;
    localparam int BLANK_CYC_DEF = 4;
    localparam int ADDR_W        = $clog2(N_DEF * N_DEF);
    localparam int DWELL_PROD_W  = DWELL_W_DEF + SPEED_W_DEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_SHOW,
        S_BLANK
    } scan_state_t;

endpackage

// File: rtl/cube_frame_dbuf.sv
// Double-buffered N*N x N frame store: the writer always targets the back
// buffer, the scanner always reads the front buffer, swap flips the roles.
module cube_frame_dbuf
    import cube_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = $clog2(N * N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          swap,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [N-1:0]  rd_data
);

    logic [N-1:0] mem0_q [N*N];
    logic [N-1:0] mem0_d [N*N];
    logic [N-1:0] mem1_q [N*N];
    logic [N-1:0] mem1_d [N*N];
    logic         sel_q, sel_d;
    logic         wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW + 1)'(N * N));

    // sel=0: front is mem0, back is mem1. Writes use the pre-swap sel.
    always_comb begin
        mem0_d = mem0_q;
        mem1_d = mem1_q;
        sel_d  = swap ? ~sel_q : sel_q;
        if (wr_ok) begin
            if (sel_q) mem0_d[wr_addr] = wr_data;
            else       mem1_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem0_q <= '{default: '0};
            mem1_q <= '{default: '0};
            sel_q  <= 1'b0;
        end else begin
            mem0_q <= mem0_d;
            mem1_q <= mem1_d;
            sel_q  <= sel_d;
        end
    end

    assign rd_data = sel_q ? mem1_q[rd_addr] : mem0_q[rd_addr];

endmodule

// File: rtl/cube_scan_engine.sv
// NxNxN light-cube scanner: per layer, latch N row bytes serially, light the
// layer for a programmable dwell, blank, and swap buffers at frame boundaries.
module cube_scan_engine
    import cube_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DWELL_W   = DWELL_W_DEF,
    parameter int SPEED_W   = SPEED_W_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [DWELL_W-1:0]     base_dwell,
    input  logic [SPEED_W-1:0]     speed,
    input  logic                   wr_en,
    input  logic [$clog2(N*N)-1:0] wr_addr,
    input  logic [N-1:0]           wr_data,
    input  logic                   swap_req,
    output logic                   swap_ack,
    output logic                   frame_start,
    output logic [N-1:0]           high_csn,
    output logic [N-1:0]           row,
    output logic [N-1:0]           row_cs
);

    localparam int AW    = $clog2(N * N);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = DWELL_W + SPEED_W;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    scan_state_t      state_q, state_d;
    logic [IDX_W-1:0] layer_q, layer_d, r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             swap_pend_q, swap_pend_d;
    logic             swap_ack_q, swap_ack_d;
    logic             frame_start_q, frame_start_d;
    logic [N-1:0]     high_csn_q, high_csn_d;
    logic [N-1:0]     row_q, row_d;
    logic [N-1:0]     row_cs_q, row_cs_d;
    logic [DWELL_W-1:0] base_eff;
    logic [CNT_W-1:0] dwell;
    logic             boundary, do_swap;
    logic [AW-1:0]    rd_addr;
    logic [N-1:0]     rd_data;

    // base*(speed+1) written as base*speed+base keeps every operand in CNT_W bits.
    assign base_eff = (base_dwell == '0) ? DWELL_W'(1) : base_dwell;
    assign dwell    = CNT_W'(base_eff) * CNT_W'(speed) + CNT_W'(base_eff);
    assign rd_addr  = AW'(int'(layer_q) * N + int'(r_q));

    cube_frame_dbuf #(.N(N), .AW(AW)) u_dbuf (
        .clk     (clk),
        .rst     (rst),
        .swap    (do_swap),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   state_d = S_SETUP;
                S_SETUP:  state_d = S_STROBE;
                S_STROBE: state_d = (r_q == LAST) ? S_SHOW : S_SETUP;
                S_SHOW:   if (cnt_q == '0) state_d = S_BLANK;
                S_BLANK:  if (cnt_q == '0) state_d = S_SETUP;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // The dwell count is reloaded on every strobe so the value sampled on SHOW entry wins.
    always_comb begin
        layer_d = layer_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        if (!enable || state_q == S_IDLE) begin
            layer_d = '0;
            r_d     = '0;
        end else begin
            case (state_q)
                S_STROBE: begin
                    r_d   = (r_q == LAST) ? '0 : r_q + 1'b1;
                    cnt_d = dwell - CNT_W'(1);
                end
                S_SHOW:  cnt_d = (cnt_q == '0) ? CNT_W'(BLANK_CYC - 1) : cnt_q - 1'b1;
                S_BLANK: begin
                    if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    else layer_d = (layer_q == LAST) ? '0 : layer_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        boundary      = enable && (state_q == S_BLANK) && (cnt_q == '0) && (layer_q == LAST);
        do_swap       = boundary && swap_pend_q;
        swap_pend_d   = do_swap ? 1'b0 : (swap_pend_q | swap_req);
        swap_ack_d    = do_swap;
        frame_start_d = enable && ((state_q == S_IDLE) || boundary);
        high_csn_d    = (state_d == S_SHOW) ? ~(N'(1) << layer_q) : '1;
        row_cs_d      = (state_d == S_STROBE) ? (N'(1) << r_q) : '0;
        row_d         = row_q;
        if (state_d == S_IDLE)       row_d = '0;
        else if (state_q == S_SETUP) row_d = rd_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_q       <= '0;
            r_q           <= '0;
            cnt_q         <= '0;
            swap_pend_q   <= 1'b0;
            swap_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
            high_csn_q    <= '1;
            row_q         <= '0;
            row_cs_q      <= '0;
        end else begin
            layer_q       <= layer_d;
            r_q           <= r_d;
            cnt_q         <= cnt_d;
            swap_pend_q   <= swap_pend_d;
            swap_ack_q    <= swap_ack_d;
            frame_start_q <= frame_start_d;
            high_csn_q    <= high_csn_d;
            row_q         <= row_d;
            row_cs_q      <= row_cs_d;
        end
    end

    assign swap_ack    = swap_ack_q;
    assign frame_start = frame_start_q;
    assign high_csn    = high_csn_q;
    assign row         = row_q;
    assign row_cs      = row_cs_q;

endmodule

// File: tb/tb_cube_scan_engine.sv
// Directed bench for cube_scan_engine (N=8): dwell/frame-length table plus
// hand sequences for buffer swap, enable drop and reset in mid-scan.
module tb_cube_scan_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] base_dwell;
    logic [3:0]  speed;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        swap_req;
    logic        swap_ack;
    logic        frame_start;
    logic [7:0]  high_csn;
    logic [7:0]  row;
    logic [7:0]  row_cs;

    int checks = 0;
    int errors = 0;

    logic [7:0] cap_row [64];
    logic [7:0] cap_cs  [64];
    int   n_strobe, frame_len, show0_len, acks_mid;
    logic ack_end;

    typedef struct {
        logic [15:0] base;
        logic [3:0]  spd;
        int          show;
        int          frame;
    } dw_vec_t;

    dw_vec_t tbl [5];

    cube_scan_engine dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .base_dwell  (base_dwell),
        .speed       (speed),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .high_csn    (high_csn),
        .row         (row),
        .row_cs      (row_cs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a[5:0];
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic wait_fs(input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (frame_start) return;
        end
        checks++;
        errors++;
        $display("FAIL frame_start_wait actual=none required=pulse within %0d cycles", limit);
    endtask

    // Called just after a negedge that showed frame_start; returns at the next one.
    task automatic run_frame();
        n_strobe  = 0;
        frame_len = 0;
        show0_len = 0;
        acks_mid  = 0;
        ack_end   = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            frame_len++;
            if (frame_start) begin
                ack_end = swap_ack;
                return;
            end
            if (row_cs != 8'h00) begin
                if (n_strobe < 64) begin
                    cap_row[n_strobe] = row;
                    cap_cs[n_strobe]  = row_cs;
                end
                n_strobe++;
            end
            if (high_csn == 8'hFE) show0_len++;
            if (swap_ack) acks_mid++;
        end
        checks++;
        errors++;
        $display("FAIL frame_end_wait actual=none required=frame_start within 2000 cycles");
    endtask

    function automatic int count_rows_ne(input int lo, input int hi, input logic [7:0] v);
        int bad = 0;
        for (int k = lo; k <= hi; k++) if (cap_row[k] !== v) bad++;
        return bad;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;

        tbl[0] = '{base: 16'd10, spd: 4'd0,  show: 10, frame: 240};
        tbl[1] = '{base: 16'd0,  spd: 4'd15, show: 16, frame: 288};
        tbl[2] = '{base: 16'd3,  spd: 4'd2,  show: 9,  frame: 232};
        tbl[3] = '{base: 16'd0,  spd: 4'd0,  show: 1,  frame: 168};
        tbl[4] = '{base: 16'd2,  spd: 4'd3,  show: 8,  frame: 224};

        rst        = 1'b1;
        enable     = 1'b0;
        base_dwell = 16'd10;
        speed      = 4'd0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        swap_req   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_high_csn", int'(high_csn), 'hFF);
        chk("rst_row", int'(row), 0);
        chk("rst_row_cs", int'(row_cs), 0);
        chk("rst_swap_ack", int'(swap_ack), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        rst = 1'b0;
        @(negedge clk);

        // Back buffer: layer 0 rows walk a single bit, every other layer 8'h55.
        for (int a = 0; a < 64; a++) wr(a, (a < 8) ? (8'h01 << a) : 8'h55);
        pulse_swap();
        enable = 1'b1;
        wait_fs(10);
        chk("fs0_swap_ack", int'(swap_ack), 0);

        run_frame();
        chk("f0_len", frame_len, 240);
        chk("f0_strobes", n_strobe, 64);
        chk("f0_rows_zero", count_rows_ne(0, 63, 8'h00), 0);
        chk("f0_ack_at_boundary", int'(ack_end), 1);
        chk("f0_ack_mid", acks_mid, 0);

        run_frame();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("f1_cs%0d", k), int'(cap_cs[k]), 1 << k);
            chk($sformatf("f1_row%0d", k), int'(cap_row[k]), 1 << k);
        end
        chk("f1_show0_len", show0_len, 10);
        chk("f1_rows_55", count_rows_ne(8, 63, 8'h55), 0);
        chk("f1_ack_end", int'(ack_end), 0);

        // Write 8'hAA into the back buffer's layer 1 and request swap twice.
        fork
            run_frame();
            begin
                repeat (5) @(negedge clk);
                for (int a = 8; a < 16; a++) wr(a, 8'hAA);
                repeat (5) @(negedge clk);
                pulse_swap();
                repeat (80) @(negedge clk);
                pulse_swap();
            end
        join
        chk("f2_layer1_still_55", count_rows_ne(8, 15, 8'h55), 0);
        chk("f2_ack_mid", acks_mid, 0);
        chk("f2_single_ack", int'(ack_end), 1);

        // swap_req sampled on the boundary edge itself.
        fork
            run_frame();
            begin
                repeat (239) @(negedge clk);
                swap_req = 1'b1;
                @(negedge clk);
                swap_req = 1'b0;
            end
        join
        chk("f3_layer1_aa", count_rows_ne(8, 15, 8'hAA), 0);
        chk("f3_no_ack", int'(ack_end), 0);
        run_frame();
        chk("f4_late_ack", int'(ack_end), 1);

        for (int t = 0; t < 5; t++) begin
            base_dwell = tbl[t].base;
            speed      = tbl[t].spd;
            wait_fs(2000);
            run_frame();
            chk($sformatf("tbl%0d_show", t), show0_len, tbl[t].show);
            chk($sformatf("tbl%0d_frame", t), frame_len, tbl[t].frame);
        end

        // Drop enable during a strobe with a swap pending.
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk);
            if (row_cs != 8'h00) found = 1'b1;
        end
        chk("strobe_seen", int'(found), 1);
        enable   = 1'b0;
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("dis_high_csn", int'(high_csn), 'hFF);
        chk("dis_row", int'(row), 0);
        chk("dis_row_cs", int'(row_cs), 0);
        repeat (3) @(negedge clk);
        chk("idle_frame_start", int'(frame_start), 0);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_frame_start", int'(frame_start), 1);
        run_frame();
        chk("reen_first_cs", int'(cap_cs[0]), 'h01);
        chk("reen_show0_len", show0_len, 8);
        chk("reen_pend_kept", int'(ack_end), 1);

        // Reset while layer 3 is lit.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (high_csn == 8'hF7) found = 1'b1;
        end
        chk("layer3_seen", int'(found), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_high_csn", int'(high_csn), 'hFF);
        chk("mrst_row", int'(row), 0);
        chk("mrst_row_cs", int'(row_cs), 0);
        chk("mrst_swap_ack", int'(swap_ack), 0);
        rst = 1'b0;
        wait_fs(10);
        run_frame();
        chk("mrst_strobes", n_strobe, 64);
        chk("mrst_buffers_clear", count_rows_ne(0, 63, 8'h00), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
